// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice blocks: program codes, scan FSM
// states and the width of the note-increment ROM words.
package synth_pkg;

  localparam int ROM_W = 32;

  localparam logic [6:0] PRG_SQUARE = 7'd0;
  localparam logic [6:0] PRG_SAW    = 7'd1;
  localparam logic [6:0] PRG_TRI    = 7'd2;
  localparam logic [6:0] PRG_PULSE  = 7'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } nco_state_e;

endpackage

// File: rtl/note_inc_rom.sv
// MIDI note to 32-bit phase increment for a 48 kHz sample rate, A4 = 440 Hz.
// Entries are round(f_note * 2^32 / 48000), folded to constants at elaboration.
module note_inc_rom
  import synth_pkg::*;
(
  input  logic [6:0]       note,
  output logic [ROM_W-1:0] inc
);

  logic [ROM_W-1:0] rom_w [128];

  for (genvar gi = 0; gi < 128; gi++) begin : g_entry
    localparam real FREQ_HZ = 440.0 * (2.0 ** ((gi - 69) / 12.0));
    localparam real STEP    = FREQ_HZ * 4294967296.0 / 48000.0;
    assign rom_w[gi] = ROM_W'($rtoi(STEP + 0.5));
  end

  assign inc = rom_w[note];

endmodule

// File: rtl/poly_nco.sv
// Time-multiplexed polyphonic NCO: one voice evaluated per clock during a
// scan, voices averaged into a single offset-binary sample per CE strobe.
module poly_nco
  import synth_pkg::*;
#(
  parameter  int VOICES   = 4,
  parameter  int PHASE_W  = 24,
  parameter  int SAMPLE_W = 8,
  localparam int VW       = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CE,
  input  logic                VOICE_WE,
  input  logic [VW-1:0]       VOICE_SEL,
  input  logic                VOICE_GATE,
  input  logic [6:0]          NOTE_NUM,
  input  logic [6:0]          PROGRAM,
  output logic [SAMPLE_W-1:0] SAMPLE_OUT,
  output logic                SAMPLE_VALID,
  output logic                BUSY,
  output logic                OVERRUN
);

  localparam int SH = $clog2(VOICES);
  localparam int AW = SAMPLE_W + VW;
  localparam logic [SAMPLE_W-1:0] MAX = '1;
  localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic               gate_reg  [VOICES];
  logic [6:0]         note_reg  [VOICES];
  logic [6:0]         prog_reg  [VOICES];
  logic [PHASE_W-1:0] phase_reg [VOICES];

  nco_state_e            state_reg, state_next;
  logic [VW-1:0]         idx_reg, idx_next;
  logic signed [AW-1:0]  acc_reg, acc_next;
  logic [SAMPLE_W-1:0]   sample_reg;
  logic                  valid_reg;
  logic                  overrun_reg;

  logic [VOICES-1:0]     wr_hit;
  logic [VOICES-1:0]     slot_hit;
  logic [ROM_W-1:0]      rom_inc;
  logic [PHASE_W-1:0]    inc_w;
  logic [SAMPLE_W-1:0]   p_w;
  logic [SAMPLE_W-1:0]   wave_w;
  logic signed [AW-1:0]  wave_ext;
  logic [SAMPLE_W-1:0]   mix_w;

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_hit
    assign wr_hit[gi]   = VOICE_WE && (VOICE_SEL == VW'(gi));
    assign slot_hit[gi] = (state_reg == SCAN) && (idx_reg == VW'(gi));
  end

  note_inc_rom u_rom (
    .note (note_reg[idx_reg]),
    .inc  (rom_inc)
  );

  assign inc_w = PHASE_W'(rom_inc >> (ROM_W - PHASE_W));
  assign p_w   = phase_reg[idx_reg][PHASE_W-1 -: SAMPLE_W];

  always_comb begin
    wave_w = MID;
    if (gate_reg[idx_reg]) begin
      case (prog_reg[idx_reg])
        PRG_SQUARE: wave_w = p_w[SAMPLE_W-1] ? '0 : MAX;
        PRG_SAW:    wave_w = p_w;
        PRG_TRI:    wave_w = p_w[SAMPLE_W-1] ? ~(p_w << 1) : (p_w << 1);
        PRG_PULSE:  wave_w = (p_w[SAMPLE_W-1 -: 2] == 2'b00) ? MAX : '0;
        default:    wave_w = MID;
      endcase
    end
  end

  // Offset binary to two's complement, sign-extended to accumulator width.
  assign wave_ext = {{(VW+1){~wave_w[SAMPLE_W-1]}}, wave_w[SAMPLE_W-2:0]};
  assign mix_w    = SAMPLE_W'(acc_reg >>> SH);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    acc_next   = acc_reg;
    case (state_reg)
      IDLE: begin
        if (CE) begin
          state_next = SCAN;
          idx_next   = '0;
          acc_next   = '0;
        end
      end
      SCAN: begin
        acc_next = acc_reg + wave_ext;
        if (idx_reg == VW'(VOICES - 1)) state_next = DONE;
        else                            idx_next   = idx_reg + 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      acc_reg     <= '0;
      sample_reg  <= MID;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      acc_reg   <= acc_next;
      valid_reg <= (state_reg == DONE);
      if (state_reg == DONE) sample_reg <= {~mix_w[SAMPLE_W-1], mix_w[SAMPLE_W-2:0]};
      if (CE && (state_reg != IDLE)) overrun_reg <= 1'b1;
    end
  end

  // A gate-changing write wins over the slot's phase advance.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < VOICES; i++) begin
        gate_reg[i]  <= 1'b0;
        note_reg[i]  <= '0;
        prog_reg[i]  <= '0;
        phase_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (wr_hit[i]) begin
          gate_reg[i] <= VOICE_GATE;
          note_reg[i] <= NOTE_NUM;
          prog_reg[i] <= PROGRAM;
        end
        if (wr_hit[i] && (!VOICE_GATE || !gate_reg[i])) begin
          phase_reg[i] <= '0;
        end else if (slot_hit[i] && gate_reg[i]) begin
          phase_reg[i] <= phase_reg[i] + inc_w;
        end
      end
    end
  end

  assign SAMPLE_OUT   = sample_reg;
  assign SAMPLE_VALID = valid_reg;
  assign BUSY         = (state_reg != IDLE);
  assign OVERRUN      = overrun_reg;

endmodule

// File: tb/tb_poly_nco.sv
// Directed bench for poly_nco at VOICES=4, PHASE_W=24, SAMPLE_W=8.
// Expected samples are hand-derived from the A4 increment 153791.
module tb_poly_nco;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CE = 1'b0;
  logic       VOICE_WE = 1'b0;
  logic [1:0] VOICE_SEL = '0;
  logic       VOICE_GATE = 1'b0;
  logic [6:0] NOTE_NUM = '0;
  logic [6:0] PROGRAM = '0;
  logic [7:0] SAMPLE_OUT;
  logic       SAMPLE_VALID;
  logic       BUSY;
  logic       OVERRUN;

  int n_vec = 0;
  int n_bad = 0;

  poly_nco #(.VOICES(4), .PHASE_W(24), .SAMPLE_W(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .CE           (CE),
    .VOICE_WE     (VOICE_WE),
    .VOICE_SEL    (VOICE_SEL),
    .VOICE_GATE   (VOICE_GATE),
    .NOTE_NUM     (NOTE_NUM),
    .PROGRAM      (PROGRAM),
    .SAMPLE_OUT   (SAMPLE_OUT),
    .SAMPLE_VALID (SAMPLE_VALID),
    .BUSY         (BUSY),
    .OVERRUN      (OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("[%0t] %s observed=%0d expected=%0d", $time, tag, obs, exp);
  endtask

  task automatic do_reset(input int cycles);
    RST = 1'b1;
    repeat (cycles) tick();
    RST = 1'b0;
  endtask

  task automatic write_voice(input int sel, input logic gate, input int note, input int prog);
    VOICE_WE   = 1'b1;
    VOICE_SEL  = 2'(sel);
    VOICE_GATE = gate;
    NOTE_NUM   = 7'(note);
    PROGRAM    = 7'(prog);
    tick();
    VOICE_WE   = 1'b0;
  endtask

  task automatic wait_valid(output logic [7:0] smp);
    int waited;
    waited = 0;
    while (!SAMPLE_VALID && waited < 20) begin
      tick();
      waited++;
    end
    check("valid_seen", 32'(SAMPLE_VALID), 1);
    smp = SAMPLE_OUT;
  endtask

  task automatic run_sample(output logic [7:0] smp);
    CE = 1'b1;
    tick();
    CE = 1'b0;
    wait_valid(smp);
  endtask

  initial begin
    logic [7:0] smp;
    int nvalid;

    // Reset values
    do_reset(3);
    check("rst_sample", 32'(SAMPLE_OUT), 128);
    check("rst_valid", 32'(SAMPLE_VALID), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_overrun", 32'(OVERRUN), 0);

    // Latency: CE on edge k, valid only after edge k+5
    CE = 1'b1;
    tick();
    CE = 1'b0;
    check("lat_busy_k", 32'(BUSY), 1);
    repeat (4) tick();
    check("lat_busy_k4", 32'(BUSY), 1);
    check("lat_valid_k4", 32'(SAMPLE_VALID), 0);
    tick();
    check("lat_busy_k5", 32'(BUSY), 0);
    check("lat_valid_k5", 32'(SAMPLE_VALID), 1);
    check("lat_sample_idle", 32'(SAMPLE_OUT), 128);
    tick();
    check("lat_valid_k6", 32'(SAMPLE_VALID), 0);

    // Four squares at phase 0 sum to full scale
    for (int v = 0; v < 4; v++) write_voice(v, 1'b1, 69, 0);
    run_sample(smp);
    check("square_x4", 32'(smp), 255);

    // Voice 0 saw, A4: phase walk and wrap after 110 samples
    do_reset(1);
    write_voice(0, 1'b1, 69, 1);
    for (int s = 1; s <= 111; s++) begin
      run_sample(smp);
      if (s == 1)   check("saw_s1", 32'(smp), 96);
      if (s == 2)   check("saw_s2", 32'(smp), 96);
      if (s == 3)   check("saw_s3", 32'(smp), 97);
      if (s == 110) check("saw_s110", 32'(smp), 159);
      if (s == 111) check("saw_s111_wrap", 32'(smp), 96);
    end

    // Rewrite with gate held high keeps the phase
    write_voice(0, 1'b1, 69, 1);
    run_sample(smp);
    check("gate_hold_keeps_phase", 32'(smp), 97);

    // Write landing in voice 0's own slot: old program used for that sample
    CE = 1'b1;
    tick();
    CE = 1'b0;
    VOICE_WE = 1'b1; VOICE_SEL = 2'd0; VOICE_GATE = 1'b1; NOTE_NUM = 7'd69; PROGRAM = 7'd0;
    tick();
    VOICE_WE = 1'b0;
    wait_valid(smp);
    check("slot_write_old_prog", 32'(smp), 97);
    run_sample(smp);
    check("slot_write_new_prog", 32'(smp), 159);

    // Unused program gives MID; gate off then on restarts phase at 0
    write_voice(0, 1'b1, 69, 5);
    run_sample(smp);
    check("prog5_mid", 32'(smp), 128);
    write_voice(0, 1'b0, 69, 1);
    run_sample(smp);
    check("gate0_mid", 32'(smp), 128);
    write_voice(0, 1'b1, 69, 1);
    run_sample(smp);
    check("retrigger_phase0", 32'(smp), 96);

    // Triangle, pulse, square, saw mix at three phase points
    do_reset(1);
    write_voice(0, 1'b1, 69, 2);
    write_voice(1, 1'b1, 69, 3);
    write_voice(2, 1'b1, 69, 0);
    write_voice(3, 1'b1, 69, 1);
    for (int s = 1; s <= 66; s++) begin
      run_sample(smp);
      if (s == 1)  check("mix4_s1", 32'(smp), 127);
      if (s == 33) check("mix4_s33", 32'(smp), 120);
      if (s == 66) check("mix4_s66", 32'(smp), 89);
    end

    // Overrun: second CE three cycles later is ignored
    do_reset(1);
    CE = 1'b1;
    tick();
    CE = 1'b0;
    tick();
    tick();
    check("ovr_before", 32'(OVERRUN), 0);
    CE = 1'b1;
    tick();
    CE = 1'b0;
    check("ovr_set", 32'(OVERRUN), 1);
    nvalid = 0;
    for (int c = 0; c < 10; c++) begin
      if (SAMPLE_VALID) nvalid++;
      tick();
    end
    check("ovr_single_valid", 32'(nvalid), 1);
    check("ovr_sticky", 32'(OVERRUN), 1);
    do_reset(1);
    check("ovr_cleared", 32'(OVERRUN), 0);

    // Reset mid-scan aborts without a valid pulse
    CE = 1'b1;
    tick();
    CE = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 10; c++) begin
      if (SAMPLE_VALID) nvalid++;
      tick();
    end
    check("abort_no_valid", 32'(nvalid), 0);
    check("abort_busy", 32'(BUSY), 0);
    check("abort_sample", 32'(SAMPLE_OUT), 128);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/poly_nco.md
# poly_nco

Time-multiplexed polyphonic numerically controlled oscillator. It is the parametrised successor of the single-voice `nco`, adding:

- a configurable voice count, phase width and sample width;
- per-voice gate, note and program registers behind a write port;
- a sample-rate strobe, a built-in averaging mixer, a valid pulse and an overrun flag.

It sits between the note/voice allocator and the audio DAC/PWM stage.

## Interface

Parameters:

- VOICES, 4, number of voices; power of two, 1..16; VW = max(1, clog2(VOICES))
- PHASE_W, 24, phase accumulator width, 16..32
- SAMPLE_W, 8, output sample width, 4..16

Ports:

- CLK  in  1  system clock; one clock domain; reset is synchronous and active-high
- RST  in  1  synchronous active-high reset
- CE  in  1  sample-rate strobe, one cycle per output sample
- VOICE_WE  in  1  write strobe for the voice registers
- VOICE_SEL  in  VW  voice index being written
- VOICE_GATE  in  1  1 = voice sounding
- NOTE_NUM  in  7  MIDI note number
- PROGRAM  in  7  waveform select
- SAMPLE_OUT  out  SAMPLE_W  mixed sample, unsigned offset binary
- SAMPLE_VALID  out  1  one-cycle pulse when SAMPLE_OUT is updated
- BUSY  out  1  high while a scan is in progress
- OVERRUN  out  1  sticky; set when CE arrives while BUSY

## Operation

- Each voice holds four registers: gate, note[6:0], program[6:0] and phase[PHASE_W-1:0].
- VOICE_WE writes gate, note and program of the voice selected by VOICE_SEL.
  - Gate 0→1: phase loads 0.
  - Gate staying 1: phase is retained.
  - Gate →0: phase clears to 0.
- Phase increment comes from a 128-entry ROM holding round(440·2^((n−69)/12)·2^32/48000) as 32-bit values. The increment used is ROM[n] >> (32−PHASE_W); note 69 gives 39370534, or 153791 at PHASE_W=24.
- Waveform: p = phase[PHASE_W-1 -: SAMPLE_W]; MAX = 2^SAMPLE_W−1; MID = 2^(SAMPLE_W−1).
  - program 0, square: MSB=0 → MAX, else 0.
  - program 1, saw: p.
  - program 2, triangle: p<<1 when MSB=0, else ~(p<<1), truncated to SAMPLE_W bits.
  - program 3, 25 % pulse: top two bits = 00 → MAX, else 0.
  - programs 4..127: MID.
  - Gate 0: MID, regardless of program.
- Mixer:
  - Each voice value is converted to signed by inverting its MSB, then accumulated in SAMPLE_W+VW bits.
  - The result is arithmetic-shifted right by clog2(VOICES) (floor), then its MSB is inverted back to offset binary.
- Each voice's sample uses its phase before the slot's increment; the phase then advances by the increment, modulo 2^PHASE_W.
- State machine:
  - IDLE: CE=1 → SCAN with idx=0, accumulator cleared.
  - SCAN: one voice per cycle. When idx = VOICES−1 → DONE; otherwise idx+1.
  - DONE: register SAMPLE_OUT, pulse SAMPLE_VALID, → IDLE.
- BUSY = (state ≠ IDLE). CE while BUSY is ignored and sets OVERRUN.
- A write to the voice currently in its SCAN slot: the slot uses the old values, and the new values apply from the next cycle. If that write is a gate change, the phase clear/load overrides that slot's phase increment.

## Timing

- Reset values: SAMPLE_OUT = MID, SAMPLE_VALID = 0, BUSY = 0, OVERRUN = 0. All voices are cleared to gate 0, note 0, program 0, phase 0, and the state is IDLE.
- RST mid-scan aborts the scan; no SAMPLE_VALID is produced for it.
- CE sampled on edge k:
  - SCAN occupies edges k+1..k+VOICES.
  - SAMPLE_OUT and SAMPLE_VALID are registered on edge k+VOICES+1. Latency is VOICES+1 cycles.
- Minimum CE spacing is VOICES+2 cycles. A CE arriving on the same edge DONE completes counts as overrun.
- A VOICE_WE write is visible on the next edge.
- The ROM is combinational, so there is no extra latency.

## Structure

- Shared package `synth_pkg` holds:
  - program encodings: PRG_SQUARE=0, PRG_SAW=1, PRG_TRI=2, PRG_PULSE=3;
  - FSM state encodings (IDLE, SCAN, DONE);
  - constant ROM_W = 32.
- Sub-module `note_inc_rom`: 7-bit note → 32-bit increment, combinational case table.
- The top level contains the FSM, the voice register file, the waveform shaper and the mixer.

## Test plan

- Reset: hold RST 3 cycles → SAMPLE_OUT=128, SAMPLE_VALID=0, BUSY=0, OVERRUN=0.
- Latency, VOICES=4: single CE at edge k → BUSY high k+1..k+5, SAMPLE_VALID only at k+5.
- VOICES=4, SAMPLE_W=8, all four voices gate 1, program 0, note 69, first CE → SAMPLE_OUT=255. Voice 0 only, program 1 → SAMPLE_OUT=96 (−128>>>2 = −32).
- Phase, PHASE_W=24, voice 0 note 69 saw: after 109 CEs, internal phase = 16763219, and the 110th sample's voice-0 p = 255.
- Overrun: CE every 3 cycles at VOICES=4 → OVERRUN=1 after the second CE, which produces no extra SAMPLE_VALID. OVERRUN holds until RST.
- Voice 0 program 5, gate 1 → voice 0 contributes MID. Then gate 0→1 mid-tone → that voice's next sample uses phase 0.
